// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_if
// Purpose  : Request/result bundle between the ALU issue logic and the
//            multi-cycle divider (operands in, HI/LO results and status out).
// Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Signed;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivZero;

    // Issue side: drives the request, observes status and results
    modport master (
        output Start, A, B, Signed,
        input  Busy, Done, Quotient, Remainder, DivZero
    );

    // Divider side
    modport slave (
        input  Start, A, B, Signed,
        output Busy, Done, Quotient, Remainder, DivZero
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle MIPS DIV/DIVU. Restoring division on operand
//            magnitudes, one quotient bit per cycle, then one sign-fixup
//            cycle that registers Quotient (LO) and Remainder (HI).
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,     // synchronous, active-low
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int                 c_cnt_w     = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_busy;

    // Working registers: r_quo starts as |A| and fills with quotient bits
    // from the right while its MSBs are shifted into the partial remainder.
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_a_raw;
    logic [c_cnt_w-1:0] r_count;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_zero;

    // Registered results, held until the next FIX
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_divzero;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_is_zero;
    logic [WIDTH:0]     w_shift;
    logic               w_fit;
    logic [WIDTH-1:0]   w_trial;
    logic               w_last_iter;

    assign w_a_neg     = bus.Signed & bus.A[WIDTH-1];
    assign w_b_neg     = bus.Signed & bus.B[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag     = w_b_neg ? -bus.B : bus.B;
    assign w_b_is_zero = (bus.B == '0);

    // Shifted partial remainder can reach 2*|B|-1, hence one extra bit.
    // The subtraction only needs the low WIDTH bits: when it is kept the
    // result is below |B| and so always fits.
    assign w_shift     = {r_rem, r_quo[WIDTH-1]};
    assign w_fit       = (w_shift >= {1'b0, r_divisor});
    assign w_trial     = w_shift[WIDTH-1:0] - r_divisor;
    assign w_last_iter = (r_count == c_last_iter);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Busy decode; zero divisor skips straight to FIX
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    w_next_state = w_b_is_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (w_last_iter) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_busy       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, restoring iterations and sign fixup of the results
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_quo       <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_a_raw     <= '0;
            r_count     <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divzero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_a_raw   <= bus.A;
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_qneg    <= w_a_neg ^ w_b_neg;
                        r_rneg    <= w_a_neg;
                        r_zero    <= w_b_is_zero;
                    end
                end
                S_CALC: begin
                    r_rem   <= w_fit ? w_trial : w_shift[WIDTH-1:0];
                    r_quo   <= {r_quo[WIDTH-2:0], w_fit};
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_a_raw;
                        r_divzero   <= 1'b1;
                    end else begin
                        // Negating 0x80000000 wraps to itself, which gives
                        // the MIPS result for the overflow case for free.
                        r_quotient  <= r_qneg ? -r_quo : r_quo;
                        r_remainder <= r_rneg ? -r_rem : r_rem;
                        r_divzero   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Busy      = w_busy;
    assign bus.Done      = r_done;
    assign bus.Quotient  = r_quotient;
    assign bus.Remainder = r_remainder;
    assign bus.DivZero   = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: directed MIPS DIV/DIVU cases,
//            control corners and randomized operands against an arithmetic
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference result straight from MIPS arithmetic (C-style truncation)
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      input logic s, output logic [31:0] q,
                                      output logic [31:0] r, output logic dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Cycle-level model: an accepted request keeps the unit busy for a fixed
    // number of cycles, then results appear with a one-cycle Done.
    int          m_left  = 0;
    bit          m_valid = 1'b0;
    logic        m_done  = 1'b0;
    logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic        m_dz = 1'b0, p_dz = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (!reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dz   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_dz;
                end
            end else if (bus.Start) begin
                model_div(bus.A, bus.B, bus.Signed, p_q, p_r, p_dz);
                m_left = (bus.B == 32'd0) ? 1 : 33;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (bus.Busy !== (m_left > 0) || bus.Done !== m_done ||
                bus.Quotient !== m_q || bus.Remainder !== m_r || bus.DivZero !== m_dz) begin
                errors++;
                $display("FAIL cycle_model t=%0t: got busy=%b done=%b q=%h r=%h dz=%b, required busy=%b done=%b q=%h r=%h dz=%b",
                         $time, bus.Busy, bus.Done, bus.Quotient, bus.Remainder, bus.DivZero,
                         (m_left > 0), m_done, m_q, m_r, m_dz);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request (Start held for the current cycle), wait for Done with
    // a bound, then check latency, busy length and results. Optionally pulses
    // Start with other operands part-way through the calculation.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input int ebusy, input int glitch_at,
                         input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        bus.A      = a;
        bus.B      = b;
        bus.Signed = s;
        bus.Start  = 1'b1;
        @(posedge clk); #1;
        bus.Start  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        bus.Signed = 1'($urandom_range(0, 1));
        lat      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat < 100) begin
            if (bus.Done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.Busy === 1'b1) busy_cnt++;
                if (lat == glitch_at) begin
                    bus.Start = 1'b1;
                    bus.A     = $urandom;
                    bus.B     = $urandom_range(1, 50);
                end else begin
                    bus.Start = 1'b0;
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        bus.Start = 1'b0;
        chk({tag, " latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(elat));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(ebusy));
        chk({tag, " quotient"}, bus.Quotient, eq);
        chk({tag, " remainder"}, bus.Remainder, er);
        chk({tag, " divzero"}, 32'(bus.DivZero), 32'(edz));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs, rdz;
        int          done_cnt;
        int          kind;

        reset      = 1'b0;
        bus.Start  = 1'b1;     // reset must win over Start
        bus.A      = 32'd50;
        bus.B      = 32'd5;
        bus.Signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.Busy), 32'd0);
        chk("reset done", 32'(bus.Done), 32'd0);
        chk("reset quotient", bus.Quotient, 32'd0);
        chk("reset remainder", bus.Remainder, 32'd0);
        chk("reset divzero", 32'(bus.DivZero), 32'd0);
        bus.Start = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed results
        do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33, 0, "u100_7");
        @(posedge clk); #1;
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33, 0, "s-7_2");
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 33, 0, "s7_-2");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 33, 0, "u_max_1");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, 33, 0, "s_min_-1");
        @(posedge clk); #1;
        do_op(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2, 1, 0, "div0");
        // Issued in the Done cycle of the previous one: back-to-back
        do_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, 33, 0, "b2b_9_3");
        @(posedge clk); #1;

        // Start pulsed mid-calculation with other operands is ignored
        do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33, 10, "start_mid_calc");
        @(posedge clk); #1;

        // Reset at calculation iteration 10 aborts with no Done afterwards
        bus.A      = 32'd1000;
        bus.B      = 32'd3;
        bus.Signed = 1'b0;
        bus.Start  = 1'b1;
        @(posedge clk); #1;
        bus.Start  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort busy", 32'(bus.Busy), 32'd0);
        chk("abort done", 32'(bus.Done), 32'd0);
        chk("abort quotient", bus.Quotient, 32'd0);
        chk("abort remainder", bus.Remainder, 32'd0);
        chk("abort divzero", 32'(bus.DivZero), 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.Done !== 1'b0) done_cnt++;
        end
        chk("abort no_done", 32'(done_cnt), 32'd0);

        // Randomized operands, biased toward edge values
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 7);
            ra   = $urandom;
            rb   = $urandom;
            rs   = 1'($urandom_range(0, 1));
            case (kind)
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
                3: ra = $urandom_range(0, 20);
                4: rb = -($urandom_range(1, 15));
                default: ;
            endcase
            model_div(ra, rb, rs, rq, rr, rdz);
            do_op(ra, rb, rs, rq, rr, rdz, (rb == 32'd0) ? 2 : 34, (rb == 32'd0) ? 1 : 33, 0, "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the ALU, executing MIPS DIV/DIVU. It inverts the multiply path and is built on repeated trial subtraction, producing a quotient (to LO) and a remainder (to HI). It uses a one-bit-per-cycle restoring algorithm on operand magnitudes, followed by a sign-fixup cycle. The pipeline stalls on Busy and writes HI/LO on Done.

## Interface

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- Start  input  1  request a division; sampled only in IDLE.
- A  input  WIDTH  dividend; sampled with Start.
- B  input  WIDTH  divisor; sampled with Start.
- Signed  input  1  1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with Start.
- Busy  output  1  high while a division is in progress (CALC or FIX).
- Done  output  1  one-cycle pulse; Quotient/Remainder are valid from this cycle.
- Quotient  output  WIDTH  result for LO; held until the next Done.
- Remainder  output  WIDTH  result for HI; held until the next Done.
- DivZero  output  1  set with Done when B was 0; held until the next Done.

## Operation

- States: IDLE, CALC, FIX.
- **IDLE**
  - On Start=1, latch the operand magnitudes: |A| and |B| when Signed, otherwise A and B raw.
  - Latch qneg = Signed & (A[31]^B[31]) and rneg = Signed & A[31].
  - Clear the partial remainder and iteration count.
  - B==0 goes to FIX with a zero-divide flag; otherwise go to CALC.
- **CALC**, 32 iterations, one per cycle:
  - Shift {R, Q} left by 1, bringing in the dividend MSB.
  - Trial = R − |B|, computed as 33-bit unsigned.
  - Trial non-negative: R = Trial, Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - After iteration 32, go to FIX.
- **FIX**
  - Normal case: Quotient = qneg ? −Q : Q and Remainder = rneg ? −R : R.
  - Zero-divide case: Quotient = 32'hFFFFFFFF, Remainder = A (raw latched dividend), DivZero = 1.
  - Otherwise DivZero = 0.
  - Done = 1 for this single cycle, then go to IDLE.
- Remainder sign always follows the dividend; |Remainder| < |B|.
- Signed 0x80000000 / 0xFFFFFFFF produces Quotient = 0x80000000, Remainder = 0. This falls out of the magnitude path (negating 0x80000000 wraps to itself); there is no overflow flag.
- Start while Busy is ignored; no queueing.
- A, B and Signed may change freely after the Start cycle.

## Timing

- Reset (reset=0 at an edge) forces:
  - state = IDLE
  - Busy = 0, Done = 0, DivZero = 0
  - Quotient = 0, Remainder = 0
- Reset overrides Start in the same cycle.
- Reset mid-operation aborts the division; no Done is issued.
- Start sampled at edge k, normal divide:
  - Busy = 1 in cycles after edges k..k+32.
  - Done = 1 in the cycle after edge k+33.
  - Busy = 0 in that same cycle.
  - Latency is 34 edges from Start to results registered.
- Start sampled at edge k, divide by zero: FIX at k+1, Done in the cycle after edge k+1, latency 2.
- Start asserted in the Done cycle is accepted (state is IDLE), giving back-to-back divides.
- Done is never high for two consecutive cycles from a single Start.
- Quotient, Remainder and DivZero change only at the FIX edge.

## Test plan

- Unsigned 100 / 7, Signed=0, Start one cycle:
  - Done exactly 34 edges later.
  - Quotient = 14, Remainder = 2, DivZero = 0.
  - Busy high for exactly 33 cycles.
- Signed −7 / 2 (A=0xFFFFFFF9, B=2):
  - Quotient = 0xFFFFFFFD, Remainder = 0xFFFFFFFF.
- Signed 7 / −2 gives Quotient = 0xFFFFFFFD, Remainder = 1.
- Unsigned 0xFFFFFFFF / 1 gives Quotient = 0xFFFFFFFF, Remainder = 0.
- Signed 0x80000000 / 0xFFFFFFFF:
  - Quotient = 0x80000000, Remainder = 0.
  - No X and no hang.
- Divide by zero, A=0x12345678, B=0:
  - Done 2 edges after Start.
  - Quotient = 0xFFFFFFFF, Remainder = 0x12345678, DivZero = 1.
  - A following 9/3 clears DivZero with Quotient = 3.
- Control corners:
  - Start pulsed mid-CALC with different operands: ignored, and the first result is unchanged.
  - reset=0 at CALC iteration 10: next cycle Busy = 0, Done = 0, outputs = 0, and no Done ever follows.
  - Start during the Done cycle: second result after exactly 34 further edges.
